// File: rtl/mul_cmd_issuer.sv
// mul_cmd_issuer: queued command initiator driving the MUL_controller compute and ExLdSt interfaces
module mul_cmd_issuer #(
  parameter int FIFO_DEPTH_BIT = 3,
  parameter int COL_NUM        = 16,
  parameter int LD_LAT         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_push,
  input  logic               cmd_type,
  input  logic [24:0]        cmd_payload,
  input  logic [COL_NUM-1:0] cmd_wdata,
  input  logic               cmd_last,
  output logic               cmd_full,
  output logic               ovf,
  output logic               busy,
  output logic               rd_valid,
  output logic [COL_NUM-1:0] rd_data,
  output logic               frame_done,
  output logic               F_in,
  input  logic               F_out,
  output logic               Compute_valid,
  output logic [24:0]        Compute_command,
  input  logic               Compute_ready,
  output logic               ExLdSt_valid,
  output logic [6:0]         ExLdSt_command,
  output logic [COL_NUM-1:0] ExLdSt_data_o,
  output logic               ExLdSt_data_oe,
  input  logic [COL_NUM-1:0] ExLdSt_data_i
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
  localparam int FB = FIFO_DEPTH_BIT;
  typedef enum logic [2:0] {IDLE, CMP, LDST, LD_WAIT, FRAME_WAIT} state_t;
  state_t state, state_nx;
  logic [FB:0] wr_ptr, rd_ptr;
  logic q_type [DEPTH];
  logic [24:0] q_payload [DEPTH];
  logic [COL_NUM-1:0] q_wdata [DEPTH];
  logic q_last [DEPTH];
  logic empty, push_ok, pop, h_type, h_last, ld_last;
  logic [24:0] h_payload;
  logic [COL_NUM-1:0] h_wdata;
  logic [3:0] cnt;
  logic ld_done;
  assign empty = wr_ptr == rd_ptr;
  assign cmd_full = (wr_ptr[FB] != rd_ptr[FB]) && (wr_ptr[FB-1:0] == rd_ptr[FB-1:0]);
  assign push_ok = cmd_push && !cmd_full;
  assign busy = (state != IDLE) || !empty;
  assign h_type = q_type[rd_ptr[FB-1:0]];
  assign h_last = q_last[rd_ptr[FB-1:0]];
  assign h_payload = q_payload[rd_ptr[FB-1:0]];
  assign h_wdata = q_wdata[rd_ptr[FB-1:0]];
  assign ld_done = (state == LD_WAIT) && (cnt == 4'd1);
  // queue storage, written at the tail; only pointers need reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_type[wr_ptr[FB-1:0]]    <= cmd_type;
      q_payload[wr_ptr[FB-1:0]] <= cmd_payload;
      q_wdata[wr_ptr[FB-1:0]]   <= cmd_wdata;
      q_last[wr_ptr[FB-1:0]]    <= cmd_last;
    end
  end
  // state, pointers, load latency counter and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf        <= 1'b0;
      cnt        <= '0;
      ld_last    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_ptr     <= push_ok ? wr_ptr + (FB+1)'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + (FB+1)'(1) : rd_ptr;
      ovf        <= ovf || (cmd_push && cmd_full);
      cnt        <= state == LDST ? 4'(LD_LAT) : state == LD_WAIT ? cnt - 4'd1 : cnt;
      ld_last    <= state == LDST ? h_last : ld_last;
      rd_valid   <= ld_done;
      rd_data    <= ld_done ? ExLdSt_data_i : rd_data;
      frame_done <= (state == FRAME_WAIT) && F_out;
    end
  end
  // next state and interface outputs decoded from state and queue head
  always_comb begin
    state_nx        = state;
    pop             = 1'b0;
    Compute_valid   = 1'b0;
    Compute_command = '0;
    F_in            = 1'b0;
    ExLdSt_valid    = 1'b0;
    ExLdSt_command  = '0;
    ExLdSt_data_o   = '0;
    ExLdSt_data_oe  = 1'b0;
    case (state)
      IDLE: state_nx = empty ? IDLE : !h_type ? CMP : Compute_ready ? LDST : IDLE;
      CMP: begin
        Compute_valid   = 1'b1;
        Compute_command = h_payload;
        F_in            = h_last;
        pop             = Compute_ready;
        state_nx        = !Compute_ready ? CMP : h_last ? FRAME_WAIT : IDLE;
      end
      LDST: begin
        ExLdSt_valid   = 1'b1;
        ExLdSt_command = h_payload[6:0];
        F_in           = h_last;
        pop            = 1'b1;
        ExLdSt_data_oe = h_payload[6];
        ExLdSt_data_o  = h_payload[6] ? h_wdata : '0;
        state_nx       = !h_payload[6] ? LD_WAIT : h_last ? FRAME_WAIT : IDLE;
      end
      LD_WAIT: state_nx = !ld_done ? LD_WAIT : ld_last ? FRAME_WAIT : IDLE;
      FRAME_WAIT: state_nx = F_out ? IDLE : FRAME_WAIT;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mul_cmd_issuer.sv
// tb_mul_cmd_issuer: directed self-checking bench for mul_cmd_issuer
module tb_mul_cmd_issuer;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_push = 1'b0, cmd_type = 1'b0, cmd_last = 1'b0;
  logic [24:0] cmd_payload = '0;
  logic [15:0] cmd_wdata = '0;
  logic cmd_full, ovf, busy, rd_valid, frame_done, F_in;
  logic [15:0] rd_data;
  logic F_out = 1'b0, Compute_ready = 1'b0;
  logic Compute_valid, ExLdSt_valid, ExLdSt_data_oe;
  logic [24:0] Compute_command;
  logic [6:0] ExLdSt_command;
  logic [15:0] ExLdSt_data_o, ExLdSt_data_i;
  int checks = 0, failures = 0, n;
  logic [15:0] bus_mem [64];
  logic [1:0] ld_pipe = '0;
  logic [5:0] ld_row = '0;

  mul_cmd_issuer #(.FIFO_DEPTH_BIT(3), .COL_NUM(16), .LD_LAT(2)) dut (
    .clk(clk), .rst(rst), .cmd_push(cmd_push), .cmd_type(cmd_type), .cmd_payload(cmd_payload),
    .cmd_wdata(cmd_wdata), .cmd_last(cmd_last), .cmd_full(cmd_full), .ovf(ovf), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .frame_done(frame_done), .F_in(F_in), .F_out(F_out),
    .Compute_valid(Compute_valid), .Compute_command(Compute_command), .Compute_ready(Compute_ready),
    .ExLdSt_valid(ExLdSt_valid), .ExLdSt_command(ExLdSt_command), .ExLdSt_data_o(ExLdSt_data_o),
    .ExLdSt_data_oe(ExLdSt_data_oe), .ExLdSt_data_i(ExLdSt_data_i)
  );

  always #5 clk = ~clk;

  // bus model: stores land in bus_mem, load data is valid only LD_LAT=2 cycles after the pulse
  always @(posedge clk) begin
    if (ExLdSt_valid && ExLdSt_data_oe) bus_mem[ExLdSt_command[5:0]] <= ExLdSt_data_o;
    ld_pipe <= {ld_pipe[0], ExLdSt_valid && !ExLdSt_command[6]};
    if (ExLdSt_valid && !ExLdSt_command[6]) ld_row <= ExLdSt_command[5:0];
  end
  assign ExLdSt_data_i = ld_pipe[1] ? bus_mem[ld_row] : 16'hDEAD;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic t, input logic [24:0] p, input logic [15:0] w, input logic l);
    cmd_push = 1'b1; cmd_type = t; cmd_payload = p; cmd_wdata = w; cmd_last = l;
    step();
    cmd_push = 1'b0; cmd_type = 1'b0; cmd_payload = '0; cmd_wdata = '0; cmd_last = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_full", cmd_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cvalid", Compute_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    step(); step();
    rst = 1'b0;
    step();
    // three computes, each stalled 4 cycles before acceptance
    push(1'b0, 25'h1, 16'h0, 1'b0);
    push(1'b0, 25'h2, 16'h0, 1'b0);
    push(1'b0, 25'h3, 16'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      repeat (4) begin
        chk("cmp_hold_valid", Compute_valid, 1);
        chk("cmp_hold_cmd", Compute_command, k);
        chk("cmp_hold_fin", F_in, 0);
        step();
      end
      Compute_ready = 1'b1;
      chk("cmp_hs_cmd", Compute_command, k);
      step();
      Compute_ready = 1'b0;
      chk("cmp_no_dup", Compute_valid, 0);
      chk("cmp_idle_cmd", Compute_command, 0);
      step();
    end
    chk("cmp_busy_end", busy, 0);
    // store then load with read-back through the bus model
    Compute_ready = 1'b1;
    push(1'b1, 25'h45, 16'hA5A5, 1'b0);
    push(1'b1, 25'h05, 16'h0, 1'b0);
    chk("st_valid", ExLdSt_valid, 1);
    chk("st_cmd", ExLdSt_command, 7'h45);
    chk("st_oe", ExLdSt_data_oe, 1);
    chk("st_data", ExLdSt_data_o, 16'hA5A5);
    step();
    chk("st_single", ExLdSt_valid, 0);
    step();
    chk("ld_valid", ExLdSt_valid, 1);
    chk("ld_cmd", ExLdSt_command, 7'h05);
    chk("ld_oe", ExLdSt_data_oe, 0);
    step();
    chk("ld_p1_rdv", rd_valid, 0);
    step();
    chk("ld_p2_rdv", rd_valid, 0);
    step();
    chk("ld_p3_rdv", rd_valid, 1);
    chk("ld_p3_data", rd_data, 16'hA5A5);
    step();
    chk("ld_p4_rdv", rd_valid, 0);
    chk("ld_p4_data", rd_data, 16'hA5A5);
    // ExLdSt held off while Compute_ready is low
    Compute_ready = 1'b0;
    push(1'b1, 25'h41, 16'h1234, 1'b0);
    repeat (5) begin
      chk("gate_valid", ExLdSt_valid, 0);
      step();
    end
    Compute_ready = 1'b1;
    chk("gate_rise_valid", ExLdSt_valid, 0);
    step();
    chk("gate_issue_valid", ExLdSt_valid, 1);
    chk("gate_issue_cmd", ExLdSt_command, 7'h41);
    chk("gate_issue_data", ExLdSt_data_o, 16'h1234);
    step();
    chk("gate_once", ExLdSt_valid, 0);
    // fill beyond capacity, then drain across the pointer wrap
    Compute_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(1'b0, 25'(32'h10 + i), 16'h0, 1'b0);
      if (i == 6) chk("fill7_full", cmd_full, 0);
      if (i == 7) begin
        chk("fill8_full", cmd_full, 1);
        chk("fill8_ovf", ovf, 0);
      end
      if (i == 8) begin
        chk("fill9_ovf", ovf, 1);
        chk("fill9_full", cmd_full, 1);
      end
    end
    Compute_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (Compute_valid) begin
        chk("drain_cmd", Compute_command, 32'h10 + n);
        n++;
      end
      step();
    end
    chk("drain_count", n, 8);
    chk("drain_ovf", ovf, 1);
    chk("drain_busy", busy, 0);
    chk("drain_full", cmd_full, 0);
    // frame: last=1 compute waits for F_out before the next entry
    push(1'b0, 25'h0ABCDEF, 16'h0, 1'b1);
    push(1'b0, 25'h55, 16'h0, 1'b0);
    chk("fr_valid", Compute_valid, 1);
    chk("fr_cmd", Compute_command, 25'h0ABCDEF);
    chk("fr_fin", F_in, 1);
    step();
    chk("fr_wait_fin", F_in, 0);
    repeat (5) begin
      chk("fr_wait_valid", Compute_valid, 0);
      chk("fr_wait_done", frame_done, 0);
      step();
    end
    F_out = 1'b1;
    step();
    F_out = 1'b0;
    chk("fr_done", frame_done, 1);
    chk("fr_done_valid", Compute_valid, 0);
    step();
    chk("fr_done_pulse", frame_done, 0);
    chk("fr_next_valid", Compute_valid, 1);
    chk("fr_next_cmd", Compute_command, 25'h55);
    step();
    chk("fr_next_once", Compute_valid, 0);
    step();
    // reset while waiting for load data with 4 entries queued
    Compute_ready = 1'b0;
    push(1'b1, 25'h05, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 25'(32'h20 + i), 16'h0, 1'b0);
    Compute_ready = 1'b1;
    step();
    chk("rs_ld_valid", ExLdSt_valid, 1);
    chk("rs_ld_oe", ExLdSt_data_oe, 0);
    step();
    chk("rs_wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_ovf", ovf, 0);
    chk("rs_rd_data", rd_data, 0);
    chk("rs_cvalid", Compute_valid, 0);
    chk("rs_evalid", ExLdSt_valid, 0);
    chk("rs_rdv", rd_valid, 0);
    step(); step();
    rst = 1'b0;
    repeat (6) begin
      chk("rs_after_busy", busy, 0);
      chk("rs_after_rdv", rd_valid, 0);
      chk("rs_after_cvalid", Compute_valid, 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_cmd_issuer.md
# mul_cmd_issuer

Synthesizable command issuer for the multiplier CIM macro: the initiator end of the `MUL_controller` command interface. Host logic pushes compute and external load/store entries into an 8-deep queue. The block issues compute commands over the `Compute_valid`/`Compute_ready` handshake and pulses ExLdSt commands, driving store data onto the bus or capturing load data. It replaces the behavioural `MUL_controller_tb` stimulus in silicon-bound tops.

## Interface
- `FIFO_DEPTH_BIT`, 3, log2 of queue depth (8 entries)
- `COL_NUM`, 16, ExLdSt data width
- `LD_LAT`, 2, cycles from the ExLdSt load pulse to valid `ExLdSt_data_i` (range 1..15)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `cmd_push` in 1: enqueue request
- `cmd_type` in 1: 0 = compute, 1 = ExLdSt
- `cmd_payload` in 25: compute command, or ExLdSt command in [6:0] (bit 6: 1 = store, 0 = load; [5:0] = row)
- `cmd_wdata` in COL_NUM: store data (ignored for load and compute)
- `cmd_last` in 1: entry closes a frame
- `cmd_full` out 1: queue full
- `ovf` out 1: sticky, push dropped while full
- `busy` out 1: FSM not IDLE or queue not empty
- `rd_valid` out 1: one-cycle pulse, load data captured
- `rd_data` out COL_NUM: captured load data
- `frame_done` out 1: one-cycle pulse on frame completion
- `F_in` out 1: frame flag to controller
- `F_out` in 1: frame completion from controller
- `Compute_valid` out 1; `Compute_command` out 25; `Compute_ready` in 1
- `ExLdSt_valid` out 1; `ExLdSt_command` out 7
- `ExLdSt_data_o` out COL_NUM; `ExLdSt_data_oe` out 1; `ExLdSt_data_i` in COL_NUM: split tristate bus, resolved at the top

## Operation
- Queue entry = {type, payload[24:0], wdata, last}. Circular buffer with wrap-around pointers plus one extra pointer bit for full/empty.
- Push is accepted only when `cmd_full`=0. A push while full is dropped and sets `ovf`; only `rst` clears `ovf`. A pop in the same cycle does not rescue a push while full.
- FSM states: IDLE, CMP, LDST, LD_WAIT, FRAME_WAIT.
- IDLE, queue non-empty:
  - Head type 0 → CMP.
  - Head type 1 and `Compute_ready`=1 → LDST.
  - Head type 1 and `Compute_ready`=0 → stay in IDLE (ExLdSt never overlaps an in-flight compute).
- CMP:
  - `Compute_valid`=1; `Compute_command`=payload; `F_in`=last.
  - All three held stable until a cycle with `Compute_ready`=1. That cycle is the handshake; the entry pops.
  - Next state: last=1 → FRAME_WAIT, else IDLE.
- LDST: exactly one cycle.
  - `ExLdSt_valid`=1; `ExLdSt_command`=payload[6:0]; `F_in`=last; entry pops.
  - Store: `ExLdSt_data_oe`=1 and `ExLdSt_data_o`=wdata in the same cycle. Next state: last ? FRAME_WAIT : IDLE.
  - Load: `ExLdSt_data_oe`=0 and a counter loads LD_LAT. Next state: LD_WAIT.
- LD_WAIT: counter decrements each cycle. At 0, `rd_data` ← `ExLdSt_data_i`, `rd_valid` pulses, next state: last ? FRAME_WAIT : IDLE.
- FRAME_WAIT: wait for `F_out`=1 (level-sampled). Then pulse `frame_done` and go to IDLE.
- Outputs not named above are 0 in every state. `Compute_command`/`ExLdSt_command` are 0 when their valid is low.

## Timing
- Reset value of every output is 0, including `ovf`, `rd_data`, and both pointers (queue empty); FSM = IDLE.
- `rst` mid-operation aborts the current handshake and flushes the queue. Outputs drop asynchronously.
- Push at cycle t makes the entry visible to the FSM at t+1. Earliest `Compute_valid` is t+2 (registered outputs).
- Compute issue with `Compute_ready` already high: valid for exactly 1 cycle. Back-to-back compute entries may issue every 2 cycles (IDLE between).
- A load pulsed at cycle p gives `rd_valid` at p+LD_LAT+1, with `rd_data` sampled at p+LD_LAT.
- `cmd_full` and `busy` are registered and combinational-free from `cmd_push`.

## Test plan
- Reset, then push 3 compute entries (payload 0x0000001/2/3) with `Compute_ready` stalled 4 cycles before each accept → each payload is held stable until its handshake, issued in order, and never duplicated.
- Push store (payload 0x45, wdata 0xA5A5), then load (payload 0x05) with the bus model returning 0xA5A5 at LD_LAT=2 → one `ExLdSt_valid` with oe=1 and data 0xA5A5; load pulse with oe=0; `rd_valid` 3 cycles later with `rd_data`=0xA5A5.
- Push an ExLdSt entry while `Compute_ready`=0 for 5 cycles → `ExLdSt_valid` stays 0 until `Compute_ready` rises, then pulses once.
- Push 9 entries while stalled → `cmd_full`=1 after 8 and `ovf`=1 after the 9th; drain the queue → exactly 8 issues, wrap-around order preserved, `ovf` still 1.
- Compute entry with last=1 → `F_in`=1 during valid; FSM waits; `F_out` high at cycle +6 → one `frame_done` pulse; the next entry is not issued before it.
- Assert `rst` while in LD_WAIT with 4 entries queued → all outputs 0 asynchronously; after release `busy`=0 and no `rd_valid` appears.
